// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory and IF->ID handshake bundle
interface if_fetch_stage_if #(
  parameter int PC_BITS    = 13,
  parameter int INSTR_BITS = 16
);
  logic                  imem_req;
  logic [PC_BITS-1:0]    imem_addr;
  logic                  imem_ack;
  logic [INSTR_BITS-1:0] imem_rdata;
  logic                  if_valid;
  logic [INSTR_BITS-1:0] if_instr;
  logic [PC_BITS-1:0]    if_pc;
  logic                  id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - IF stage: PC register, imem request/ack, skid-buffered output to ID
module if_fetch_stage #(
  parameter int                 PC_BITS    = 13,
  parameter int                 INSTR_BITS = 16,
  parameter logic [PC_BITS-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] npc_in,
  input  logic               redirect,
  output logic [PC_BITS-1:0] pc_plus1,
  if_fetch_stage_if.master   bus
);

  typedef enum logic [1:0] {FETCH, STALL, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [PC_BITS-1:0]    pc, pc_nxt;
  logic [PC_BITS-1:0]    req_addr, req_addr_nxt;
  logic [INSTR_BITS-1:0] skid_instr, skid_instr_nxt;
  logic [PC_BITS-1:0]    skid_pc, skid_pc_nxt;
  logic                  out_valid, out_valid_nxt;
  logic [INSTR_BITS-1:0] out_instr, out_instr_nxt;
  logic [PC_BITS-1:0]    out_pc, out_pc_nxt;
  logic                  slot_free;

  assign pc_plus1      = pc + 1'b1;
  assign slot_free     = !out_valid || bus.id_ready;
  // While draining, the memory still owns the old address; pc already holds the target.
  assign bus.imem_addr = (state == DRAIN) ? req_addr : pc;
  assign bus.imem_req  = ((state == FETCH) || (state == DRAIN)) && !rst;
  assign bus.if_valid  = out_valid;
  assign bus.if_instr  = out_instr;
  assign bus.if_pc     = out_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid_instr <= '0;
      skid_pc    <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      out_valid  <= out_valid_nxt;
      out_instr  <= out_instr_nxt;
      out_pc     <= out_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_addr_nxt   = req_addr;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;
    out_valid_nxt  = out_valid;
    out_instr_nxt  = out_instr;
    out_pc_nxt     = out_pc;

    case (state)
      FETCH: begin
        if (redirect) begin
          out_valid_nxt = 1'b0;
          pc_nxt        = npc_in;
          if (!bus.imem_ack) begin
            req_addr_nxt = pc;
            state_nxt    = DRAIN;
          end
        end else if (bus.imem_ack) begin
          pc_nxt = npc_in;
          if (slot_free) begin
            out_valid_nxt = 1'b1;
            out_instr_nxt = bus.imem_rdata;
            out_pc_nxt    = pc;
          end else begin
            skid_instr_nxt = bus.imem_rdata;
            skid_pc_nxt    = pc;
            state_nxt      = STALL;
          end
        end else if (bus.id_ready) begin
          out_valid_nxt = 1'b0;
        end
      end

      STALL: begin
        if (redirect) begin
          out_valid_nxt = 1'b0;
          pc_nxt        = npc_in;
          state_nxt     = FETCH;
        end else if (bus.id_ready) begin
          out_instr_nxt = skid_instr;
          out_pc_nxt    = skid_pc;
          state_nxt     = FETCH;
        end
      end

      DRAIN: begin
        if (redirect) begin
          out_valid_nxt = 1'b0;
          pc_nxt        = npc_in;
        end else if (bus.imem_ack) begin
          state_nxt = FETCH;
        end
      end

      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;
  localparam int PC_BITS    = 13;
  localparam int INSTR_BITS = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               redir;
  logic [PC_BITS-1:0] target;
  logic               id_ready;
  logic               auto_ack;
  logic               man_ack;
  logic [PC_BITS-1:0] npc_in;
  logic [PC_BITS-1:0] pc_plus1;

  int n_checks = 0;
  int n_fails  = 0;

  if_fetch_stage_if #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS)) bus ();

  if_fetch_stage #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .RESET_PC('0)) dut (
    .clk      (clk),
    .rst      (rst),
    .npc_in   (npc_in),
    .redirect (redir),
    .pc_plus1 (pc_plus1),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Next-PC mux and memory: instruction word = {3'b101, address}.
  assign npc_in         = redir ? target : pc_plus1;
  assign bus.imem_ack   = auto_ack ? bus.imem_req : man_ack;
  assign bus.imem_rdata = {3'b101, bus.imem_addr};
  assign bus.id_ready   = id_ready;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; redir = 1'b0; target = '0; id_ready = 1'b1;
    auto_ack = 1'b1; man_ack = 1'b0;

    // Reset state
    step(); step();
    check("rst_valid", bus.if_valid, 0);
    check("rst_instr", bus.if_instr, 0);
    check("rst_pc", bus.if_pc, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_pc_plus1", pc_plus1, 1);
    rst = 1'b0;
    #1;
    check("t1_req", bus.imem_req, 1);

    // 1: zero-wait streaming
    step();
    check("t1_pc0", bus.if_pc, 0);
    check("t1_instr0", bus.if_instr, 16'hA000);
    check("t1_valid0", bus.if_valid, 1);
    step(); check("t1_pc1", bus.if_pc, 1);
    step(); check("t1_pc2", bus.if_pc, 2);
    step(); check("t1_pc3", bus.if_pc, 3);
    check("t1_valid3", bus.if_valid, 1);

    // 2: backpressure for 3 clocks, skid then in-order delivery
    id_ready = 1'b0;
    step();
    check("t2_req_stall", bus.imem_req, 0);
    check("t2_pc_hold_a", bus.if_pc, 3);
    step();
    check("t2_pc_hold_b", bus.if_pc, 3);
    check("t2_instr_hold", bus.if_instr, 16'hA003);
    check("t2_req_stall_b", bus.imem_req, 0);
    step();
    check("t2_pc_hold_c", bus.if_pc, 3);
    id_ready = 1'b1;
    step();
    check("t2_skid_pc", bus.if_pc, 4);
    check("t2_skid_instr", bus.if_instr, 16'hA004);
    check("t2_skid_valid", bus.if_valid, 1);
    check("t2_addr5", bus.imem_addr, 5);
    step(); check("t2_pc5", bus.if_pc, 5);
    step(); check("t2_pc6", bus.if_pc, 6);

    // 3: redirect with same-cycle ack
    redir = 1'b1; target = 13'h0A0;
    step();
    redir = 1'b0;
    check("t3_valid_drop", bus.if_valid, 0);
    check("t3_addr", bus.imem_addr, 13'h0A0);
    step();
    check("t3_pc", bus.if_pc, 13'h0A0);
    check("t3_instr", bus.if_instr, 16'hA0A0);
    check("t3_valid", bus.if_valid, 1);

    // 4: slow memory, redirect during the wait
    auto_ack = 1'b0; man_ack = 1'b0;
    #1;
    check("t4_addr_old", bus.imem_addr, 13'h0A1);
    redir = 1'b1; target = 13'h100;
    step();
    redir = 1'b0;
    check("t4_drain_addr_a", bus.imem_addr, 13'h0A1);
    check("t4_drain_req", bus.imem_req, 1);
    check("t4_drain_valid", bus.if_valid, 0);
    step();
    check("t4_drain_addr_b", bus.imem_addr, 13'h0A1);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check("t4_new_addr", bus.imem_addr, 13'h100);
    check("t4_dropped", bus.if_valid, 0);
    check("t4_new_req", bus.imem_req, 1);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0; auto_ack = 1'b1;
    check("t4_pc", bus.if_pc, 13'h100);
    check("t4_instr", bus.if_instr, 16'hA100);
    check("t4_valid", bus.if_valid, 1);

    // 5: PC wrap
    redir = 1'b1; target = 13'h1FFF;
    step();
    redir = 1'b0;
    #1;
    check("t5_addr_max", bus.imem_addr, 13'h1FFF);
    check("t5_pc_plus1_wrap", pc_plus1, 0);
    step();
    check("t5_pc_max", bus.if_pc, 13'h1FFF);
    check("t5_instr_max", bus.if_instr, 16'hBFFF);
    check("t5_addr_wrap", bus.imem_addr, 0);
    step();
    check("t5_pc_wrap", bus.if_pc, 0);
    check("t5_instr_wrap", bus.if_instr, 16'hA000);

    // 6: reset while stalled with a full skid
    id_ready = 1'b0;
    step();
    check("t6_stall_req", bus.imem_req, 0);
    rst = 1'b1;
    #1;
    check("t6_req_in_rst", bus.imem_req, 0);
    step();
    check("t6_valid", bus.if_valid, 0);
    check("t6_addr_reset", bus.imem_addr, 0);
    check("t6_req_rst", bus.imem_req, 0);
    check("t6_pc_clr", bus.if_pc, 0);
    rst = 1'b0; id_ready = 1'b1;
    step();
    check("t6_restart_pc", bus.if_pc, 0);
    check("t6_restart_valid", bus.if_valid, 1);
    step();
    check("t6_next_pc", bus.if_pc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
